// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        S_RST,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, instr} fetch entries between memory response and decode.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: push ignored when full without a same-cycle pop; flush beats push/pop.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter  int DEPTH = BUF_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [31:0]      push_pc,
    input  logic [31:0]      push_instr,
    input  logic             pop,
    output logic [31:0]      head_pc,
    output logic [31:0]      head_instr,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    assign head_pc    = mem[rd_ptr].pc;
    assign head_instr = mem[rd_ptr].instr;

    // Entry storage: written only on an accepted push, never reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
        end
    end

    // Pointers and occupancy; reset and flush both empty the buffer.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding imem requests, buffered {pc,instr} to decode.
// Latency: request accepted at N, response at N+k, entry valid to decode at N+k+1.
// Backpressure: requests issue only while buffer entries + outstanding < BUF_DEPTH; pc frozen otherwise.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC,
    parameter int          BUF_DEPTH = fetch_pkg::BUF_DEPTH,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    output logic [31:0] pc_out,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_t     state;
    logic [31:0]      req_pc_q;
    logic             outstanding;

    logic [CNT_W-1:0] buf_count;
    logic             buf_empty;
    logic             buf_full;
    logic [31:0]      head_pc;
    logic [31:0]      head_instr;

    logic [CNT_W:0]   inflight;
    logic             credit;
    logic             req_fire;
    logic             pop;
    logic             push;

    // Credit counts buffered entries plus the request still in flight, using
    // the occupancy from before this cycle's pop.
    assign inflight = {1'b0, buf_count} + {{CNT_W{1'b0}}, outstanding};
    assign credit   = inflight < (CNT_W + 1)'(BUF_DEPTH);

    assign imem_req_valid = (state == S_ISSUE) && credit;
    assign imem_addr      = {pc_out[31:2], 2'b00};
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign id_valid = !buf_empty;
    assign id_pc    = id_valid ? head_pc : 32'h0;
    assign id_instr = id_valid ? head_instr : NOP_INSTR;
    assign pop      = id_valid && id_ready;

    // A response is kept only while waiting on a live request and no redirect
    // is flushing this cycle.
    assign push = (state == S_WAIT) && imem_rsp_valid && !redirect && (!buf_full || pop);

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .push_pc    (req_pc_q),
        .push_instr (imem_rsp_data),
        .pop        (pop),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (buf_count),
        .empty      (buf_empty),
        .full       (buf_full)
    );

    // Fetch FSM with PC register, request PC capture and outstanding flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_RST;
            pc_out      <= RESET_PC;
            req_pc_q    <= 32'h0;
            outstanding <= 1'b0;
        end else begin
            case (state)
                S_RST: begin
                    if (redirect) begin
                        pc_out <= next_pc;
                    end
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (req_fire) begin
                        req_pc_q    <= pc_out;
                        outstanding <= 1'b1;
                        pc_out      <= next_pc;
                        state       <= redirect ? S_DRAIN : S_WAIT;
                    end else if (redirect) begin
                        pc_out <= next_pc;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        pc_out <= next_pc;
                    end
                    if (imem_rsp_valid) begin
                        outstanding <= 1'b0;
                        state       <= S_ISSUE;
                    end else if (redirect) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (redirect) begin
                        pc_out <= next_pc;
                    end
                    if (imem_rsp_valid) begin
                        outstanding <= 1'b0;
                        state       <= S_ISSUE;
                    end
                end
                default: begin
                    state       <= S_RST;
                    outstanding <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner-case sequences,
// and randomized traffic checked every cycle against a queue-based reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] next_pc;
    logic [31:0] pc_out;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    always #5 clock = ~clock;

    // Next-PC logic stand-in: sequential pc+4 unless the bench redirects.
    assign next_pc = redirect ? redirect_target : pc_out + 32'd4;

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .next_pc        (next_pc),
        .redirect       (redirect),
        .pc_out         (pc_out),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_req_pc = 32'h0;
    bit          m_pend = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_idle = 1'b1;

    function automatic bit m_reqv();
        return !m_idle && !m_pend && (mq.size() < BUF_DEPTH);
    endfunction

    task automatic model_step(input bit rst, input bit rdy, input bit mrdy, input bit redir,
                              input logic [31:0] tgt, input bit rsp, input logic [31:0] rdata);
        bit fire;
        bit pop;
        bit push;
        if (rst) begin
            mq.delete();
            m_pc = RESET_PC;
            m_pend = 1'b0;
            m_stale = 1'b0;
            m_idle = 1'b1;
            return;
        end
        if (m_idle) begin
            m_idle = 1'b0;
            if (redir) begin
                mq.delete();
                m_pc = tgt;
            end
            return;
        end
        fire = m_reqv() && mrdy;
        pop  = (mq.size() > 0) && rdy;
        push = m_pend && !m_stale && rsp && !redir;
        if (m_pend && rsp) begin
            m_pend = 1'b0;
            m_stale = 1'b0;
        end
        if (redir) begin
            mq.delete();
            if (m_pend) m_stale = 1'b1;
            if (fire) begin
                m_pend = 1'b1;
                m_stale = 1'b1;
            end
            m_pc = tgt;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{pc: m_req_pc, instr: rdata});
            if (fire) begin
                m_pend = 1'b1;
                m_req_pc = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_model();
        bit          ev;
        bit          rv;
        logic [31:0] epc;
        logic [31:0] ein;
        rv  = m_reqv();
        ev  = mq.size() > 0;
        epc = ev ? mq[0].pc : 32'h0;
        ein = ev ? mq[0].instr : NOP_INSTR;
        chk("m_pc_out", pc_out, m_pc);
        chk("m_req_valid", {31'd0, imem_req_valid}, {31'd0, rv});
        if (rv) chk("m_imem_addr", imem_addr, m_pc & 32'hFFFF_FFFC);
        chk("m_id_valid", {31'd0, id_valid}, {31'd0, ev});
        chk("m_id_pc", id_pc, epc);
        chk("m_id_instr", id_instr, ein);
    endtask

    // ---------------- memory model ----------------
    int          mem_left = 0;
    int          mem_lat = 1;
    bit          mem_rand = 1'b0;
    logic [31:0] mem_addr = 32'h0;

    // One clock cycle: drive inputs at the falling edge, advance the model,
    // then check the DUT at the next falling edge.
    task automatic cycle(input bit rst, input bit rdy, input bit mrdy, input bit redir,
                         input logic [31:0] tgt);
        reset = rst;
        id_ready = rdy;
        imem_req_ready = mrdy;
        redirect = redir;
        redirect_target = tgt;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = $urandom;
        if (mem_left > 0) begin
            mem_left--;
            if (mem_left == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = mem_word(mem_addr);
            end
        end
        if (!rst && imem_req_valid && mrdy) begin
            mem_left = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
            mem_addr = imem_addr;
        end
        model_step(rst, rdy, mrdy, redir, tgt, imem_rsp_valid, imem_rsp_data);
        @(posedge clock);
        @(negedge clock);
        check_model();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rdy;
        bit          mrdy;
        bit          e_req;
        logic [31:0] e_pc;
        bit          e_idv;
        logic [31:0] e_idpc;
    } vec_t;

    function automatic vec_t mk(input bit rdy, input bit mrdy, input bit r, input logic [31:0] pc,
                                input bit v, input logic [31:0] idpc);
        vec_t t;
        t.rdy = rdy; t.mrdy = mrdy; t.e_req = r; t.e_pc = pc; t.e_idv = v; t.e_idpc = idpc;
        return t;
    endfunction

    vec_t tv[29];

    initial begin
        // Startup, 1-cycle memory, one instruction per two cycles.
        tv[0]  = mk(1, 1, 0, 32'h0040_0000, 0, 32'h0);
        tv[1]  = mk(1, 1, 1, 32'h0040_0000, 0, 32'h0);
        tv[2]  = mk(1, 1, 0, 32'h0040_0004, 0, 32'h0);
        tv[3]  = mk(1, 1, 1, 32'h0040_0004, 1, 32'h0040_0000);
        tv[4]  = mk(1, 1, 0, 32'h0040_0008, 0, 32'h0);
        tv[5]  = mk(1, 1, 1, 32'h0040_0008, 1, 32'h0040_0004);
        tv[6]  = mk(1, 1, 0, 32'h0040_000C, 0, 32'h0);
        tv[7]  = mk(1, 1, 1, 32'h0040_000C, 1, 32'h0040_0008);
        // Decode stalled for 10 cycles: buffer fills to 2, requests stop, pc frozen.
        tv[8]  = mk(0, 1, 0, 32'h0040_0010, 0, 32'h0);
        tv[9]  = mk(0, 1, 1, 32'h0040_0010, 1, 32'h0040_000C);
        tv[10] = mk(0, 1, 0, 32'h0040_0014, 1, 32'h0040_000C);
        for (int i = 11; i <= 17; i++) tv[i] = mk(0, 1, 0, 32'h0040_0014, 1, 32'h0040_000C);
        // Release: entries drain in order, fetch resumes.
        tv[18] = mk(1, 1, 0, 32'h0040_0014, 1, 32'h0040_000C);
        tv[19] = mk(1, 1, 1, 32'h0040_0014, 1, 32'h0040_0010);
        tv[20] = mk(1, 1, 0, 32'h0040_0018, 0, 32'h0);
        // Memory not ready for 5 cycles: request held, address and pc stable.
        tv[21] = mk(1, 0, 1, 32'h0040_0018, 1, 32'h0040_0014);
        for (int i = 22; i <= 25; i++) tv[i] = mk(1, 0, 1, 32'h0040_0018, 0, 32'h0);
        tv[26] = mk(1, 1, 1, 32'h0040_0018, 0, 32'h0);
        tv[27] = mk(1, 1, 0, 32'h0040_001C, 0, 32'h0);
        tv[28] = mk(1, 1, 1, 32'h0040_001C, 1, 32'h0040_0018);

        cycle(1, 0, 0, 0, 32'h0);
        cycle(1, 0, 0, 0, 32'h0);

        for (int i = 0; i < 29; i++) begin
            chk($sformatf("tv%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, tv[i].e_req});
            chk($sformatf("tv%0d_pc_out", i), pc_out, tv[i].e_pc);
            if (tv[i].e_req) chk($sformatf("tv%0d_imem_addr", i), imem_addr, tv[i].e_pc);
            chk($sformatf("tv%0d_id_valid", i), {31'd0, id_valid}, {31'd0, tv[i].e_idv});
            chk($sformatf("tv%0d_id_pc", i), id_pc, tv[i].e_idpc);
            chk($sformatf("tv%0d_id_instr", i), id_instr,
                tv[i].e_idv ? mem_word(tv[i].e_idpc) : NOP_INSTR);
            if (i < 28) cycle(0, tv[i].rdy, tv[i].mrdy, 0, 32'h0);
        end

        // Redirect while waiting; stale response arrives 3 cycles after the request.
        mem_lat = 3;
        cycle(0, 1, 1, 0, 32'h0);
        chk("rw_wait_id_valid", {31'd0, id_valid}, 32'd0);
        mem_lat = 1;
        cycle(0, 1, 1, 1, 32'h0040_0100);
        chk("rw_pc_after_redirect", pc_out, 32'h0040_0100);
        chk("rw_drain_req_valid", {31'd0, imem_req_valid}, 32'd0);
        cycle(0, 1, 1, 0, 32'h0);
        chk("rw_drain_id_valid", {31'd0, id_valid}, 32'd0);
        cycle(0, 1, 1, 0, 32'h0);
        chk("rw_stale_dropped", {31'd0, id_valid}, 32'd0);
        chk("rw_refetch_addr", imem_addr, 32'h0040_0100);
        chk("rw_refetch_valid", {31'd0, imem_req_valid}, 32'd1);
        cycle(0, 1, 1, 0, 32'h0);
        chk("rw_inflight_id_valid", {31'd0, id_valid}, 32'd0);
        cycle(0, 1, 1, 0, 32'h0);
        chk("rw_target_id_pc", id_pc, 32'h0040_0100);
        chk("rw_target_instr", id_instr, mem_word(32'h0040_0100));

        // Redirect coinciding with a response and a pop.
        cycle(0, 0, 1, 0, 32'h0);
        chk("rp_pre_id_pc", id_pc, 32'h0040_0100);
        cycle(0, 1, 1, 1, 32'h0040_0100);
        chk("rp_flushed_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rp_next_fetch_addr", imem_addr, 32'h0040_0100);
        cycle(0, 1, 1, 0, 32'h0);
        cycle(0, 1, 1, 0, 32'h0);
        chk("rp_target_id_pc", id_pc, 32'h0040_0100);
        chk("rp_target_instr", id_instr, mem_word(32'h0040_0100));

        // Reset with a request outstanding; late response lands in the idle cycle.
        mem_lat = 2;
        cycle(0, 1, 1, 0, 32'h0);
        mem_lat = 1;
        cycle(1, 1, 1, 0, 32'h0);
        chk("rst_pc_out", pc_out, RESET_PC);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0000_0013);
        cycle(0, 1, 1, 0, 32'h0);
        chk("rst_late_rsp_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_first_fetch_addr", imem_addr, 32'h0040_0000);
        cycle(0, 1, 1, 0, 32'h0);
        cycle(0, 1, 1, 0, 32'h0);
        chk("rst_first_id_pc", id_pc, 32'h0040_0000);
        chk("rst_first_instr", id_instr, mem_word(32'h0040_0000));

        // Randomized traffic against the reference model.
        mem_rand = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                for (int r = 0; r < 3; r++) cycle(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 32'h0);
            end else begin
                cycle(0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                      $urandom_range(0, 19) == 0, $urandom);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
